sign_extender: RTL and testbench



---
 rtl/sign_extender_if.sv | 16 +
 rtl/sign_extender.sv | 144 ++++++++++++++
 tb/tb_sign_extender.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sign_extender_if.sv
// Stream control and clock/reset bundles shared by the sample-side blocks.

interface clk_rstn_intrf;
  logic clk;
  logic rstn;
  modport slave  (input clk, input rstn);
  modport master (output clk, output rstn);
endinterface

interface axi_ctr_intrf;
  logic tvalid;
  logic tready;
  logic tlast;
  modport s_axis (input tvalid, input tlast, output tready);
  modport m_axis (output tvalid, output tlast, input tready);
endinterface

// File: rtl/sign_extender.sv
// Sign-extends four packed samples per stream beat by one bit, behind a
// two-entry skid buffer, and checks tlast framing against frame_beats.

module sign_extender #(
  parameter int width       = 8,
  parameter int frame_beats = 16
) (
  clk_rstn_intrf.slave         clk_rstn_i,
  axi_ctr_intrf.s_axis         s_axis,
  axi_ctr_intrf.m_axis         m_axis,
  input  logic [0:3][width-1:0] data_i,
  output logic [0:3][width:0]   data_o,
  output logic                  frame_err_o
);

  localparam int CNT_W = (frame_beats > 2) ? $clog2(frame_beats) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(frame_beats - 1);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  typedef logic [0:3][width:0] beat_t;

  if (!(width == 8 || width == 16)) begin : g_bad_width
    $error("sign_extender: width must be 8 or 16, got %0d", width);
  end
  if (frame_beats < 2) begin : g_bad_frame
    $error("sign_extender: frame_beats must be >= 2, got %0d", frame_beats);
  end

  // Replicate each lane's sign bit; lanes are handled independently.
  function automatic beat_t sign_ext(input logic [0:3][width-1:0] d);
    beat_t r;
    for (int k = 0; k < 4; k++) begin
      r[k] = {d[k][width-1], d[k]};
    end
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  beat_t            out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  beat_t            skid_data_q, skid_data_d;
  logic             skid_last_q, skid_last_d;
  logic             vld_q, vld_d;
  logic             tready_q, tready_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;

  logic accept;
  logic emit;
  logic cnt_at_end;

  assign accept     = s_axis.tvalid && tready_q;
  assign emit       = vld_q && m_axis.tready;
  assign cnt_at_end = (beat_cnt_q == CNT_MAX);

  // Skid-buffer FSM: output register first, skid register only when the sink stalls.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_data_d = sign_ext(data_i);
          out_last_d = s_axis.tlast;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && emit) begin
          out_data_d = sign_ext(data_i);
          out_last_d = s_axis.tlast;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          skid_data_d = sign_ext(data_i);
          skid_last_d = s_axis.tlast;
          state_d     = ST_FULL;
        end
      end
      ST_FULL: begin
        if (emit) begin
          out_data_d = skid_data_q;
          out_last_d = skid_last_q;
          state_d    = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    vld_d    = (state_d != ST_EMPTY);
    tready_d = (state_d != ST_FULL);
  end

  // Frame checker: an error is tlast disagreeing with the end-of-frame position.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_d      = 1'b0;
    if (accept) begin
      err_d = (s_axis.tlast != cnt_at_end);
      if (s_axis.tlast || cnt_at_end) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // State, data and framing registers; everything clears on reset.
  always_ff @(posedge clk_rstn_i.clk or negedge clk_rstn_i.rstn) begin
    if (!clk_rstn_i.rstn) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      vld_q       <= 1'b0;
      tready_q    <= 1'b0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      vld_q       <= vld_d;
      tready_q    <= tready_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = vld_q;
  assign m_axis.tlast  = out_last_q;
  assign data_o        = out_data_q;
  assign frame_err_o   = err_q;

endmodule

// File: tb/tb_sign_extender.sv
// Randomized and directed bench for sign_extender at width 8 and 16,
// both instances sharing the same stream control.

module tb_sign_extender;

  localparam int FB = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  clk_rstn_intrf cr();
  axi_ctr_intrf  s8(), m8(), s16(), m16();

  logic              s_tvalid = 1'b0;
  logic              s_tlast  = 1'b0;
  logic              m_tready = 1'b0;
  logic [0:3][15:0]  din16 = '0;
  logic [0:3][7:0]   din8;
  logic [0:3][8:0]   dout8;
  logic [0:3][16:0]  dout16;
  logic              err8, err16;

  assign cr.clk    = clk;
  assign cr.rstn   = rstn;
  assign s8.tvalid = s_tvalid;
  assign s8.tlast  = s_tlast;
  assign s16.tvalid = s_tvalid;
  assign s16.tlast  = s_tlast;
  assign m8.tready  = m_tready;
  assign m16.tready = m_tready;

  always_comb begin
    for (int k = 0; k < 4; k++) din8[k] = din16[k][7:0];
  end

  sign_extender #(.width(8), .frame_beats(FB)) dut8 (
    .clk_rstn_i (cr), .s_axis (s8), .m_axis (m8),
    .data_i (din8), .data_o (dout8), .frame_err_o (err8));

  sign_extender #(.width(16), .frame_beats(FB)) dut16 (
    .clk_rstn_i (cr), .s_axis (s16), .m_axis (m16),
    .data_i (din16), .data_o (dout16), .frame_err_o (err16));

  typedef struct packed {
    logic [63:0] d;
    logic        last;
  } beat_t;

  beat_t q[$];
  int    frame_idx = 0;
  bit    exp_rdy = 0;
  bit    exp_err = 0;
  int    total = 0;
  int    bad = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected value of each lane = its signed integer value, in width+1 bits.
  function automatic logic [35:0] ext8(input logic [63:0] d);
    logic [35:0] r;
    for (int k = 0; k < 4; k++) begin
      logic signed [7:0] b;
      int v;
      b = d[(3-k)*16 +: 8];
      v = b;
      r[(3-k)*9 +: 9] = v[8:0];
    end
    return r;
  endfunction

  function automatic logic [67:0] ext16(input logic [63:0] d);
    logic [67:0] r;
    for (int k = 0; k < 4; k++) begin
      logic signed [15:0] h;
      int v;
      h = d[(3-k)*16 +: 16];
      v = h;
      r[(3-k)*17 +: 17] = v[16:0];
    end
    return r;
  endfunction

  task automatic check_outputs();
    check("vld8",   m8.tvalid,  q.size() > 0);
    check("vld16",  m16.tvalid, q.size() > 0);
    check("rdy8",   s8.tready,  exp_rdy);
    check("rdy16",  s16.tready, exp_rdy);
    check("err8",   err8,  exp_err);
    check("err16",  err16, exp_err);
    if (q.size() > 0) begin
      check("data8",  dout8,  ext8(q[0].d));
      check("data16", dout16, ext16(q[0].d));
      check("last8",  m8.tlast,  q[0].last);
      check("last16", m16.tlast, q[0].last);
    end
  endtask

  // One clock cycle: drive at negedge, advance the model, check at next negedge.
  task automatic step(input bit v, input bit l, input logic [63:0] d, input bit r);
    bit acc, emt;
    s_tvalid = v;
    s_tlast  = l;
    din16    = d;
    m_tready = r;
    acc = v && exp_rdy;
    emt = (q.size() > 0) && r;
    if (emt) void'(q.pop_front());
    exp_err = 0;
    if (acc) begin
      q.push_back('{d: d, last: l});
      exp_err = (l && frame_idx != FB-1) || (!l && frame_idx == FB-1);
      frame_idx = (l || frame_idx == FB-1) ? 0 : frame_idx + 1;
    end
    exp_rdy = (q.size() < 2);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
    frame_idx = 0;
    exp_rdy = 0;
    exp_err = 0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [6:0] bp;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_rdy",  s8.tready, 1'b0);
    check("rst_vld",  m8.tvalid, 1'b0);
    check("rst_last", m16.tlast, 1'b0);
    check("rst_d8",   dout8,  '0);
    check("rst_d16",  dout16, '0);
    check("rst_err",  err16, 1'b0);
    rstn = 1'b1;
    #1 check("rdy_before_edge", s8.tready, 1'b0);

    step(0, 0, '0, 1);
    // Sign-extension vectors against literal expectations.
    step(1, 0, {16'h007F, 16'h0080, 16'h00FF, 16'h0000}, 1);
    check("ext8_lit", dout8, {9'h07F, 9'h180, 9'h1FF, 9'h000});
    step(1, 0, {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001}, 1);
    check("ext16_lit", dout16, {17'h18000, 17'h07FFF, 17'h1FFFF, 17'h00001});
    // Close the partial frame with an early last, then drain.
    step(1, 1, rnd64(), 1);
    step(0, 0, '0, 1);

    // Full frame, sink always ready.
    for (int i = 0; i < FB; i++) step(1, i == FB-1, rnd64(), 1);
    step(0, 0, '0, 1);

    // Backpressure pattern with source always valid.
    bp = 7'b1001011;
    for (int i = 6; i >= 0; i--) step(1, 0, rnd64(), bp[i]);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

    // Early last at beat 5 (frame restarts after a previous early-last close).
    step(1, 1, rnd64(), 1);
    for (int i = 0; i < 6; i++) step(1, i == 5, rnd64(), 1);
    // Missing last: 17 beats without tlast.
    for (int i = 0; i < FB+1; i++) step(1, 0, rnd64(), 1);
    step(1, 1, rnd64(), 1);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rnd64(),
           $urandom_range(0, 2) != 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

    // Fill both registers, then reset asynchronously mid-cycle.
    step(1, 0, rnd64(), 0);
    step(1, 0, rnd64(), 0);
    step(1, 0, rnd64(), 0);
    check("full_rdy", s8.tready, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("arst_vld8",  m8.tvalid,  1'b0);
    check("arst_vld16", m16.tvalid, 1'b0);
    check("arst_rdy",   s16.tready, 1'b0);
    check("arst_d8",    dout8, '0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(1, 0, rnd64(), 1);
    step(1, 0, {16'hFF80, 16'h0001, 16'h7F7F, 16'h8080}, 1);
    step(0, 0, '0, 1);
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 1) != 0, 0, rnd64(), $urandom_range(0, 1) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
